uart_tx_port: RTL

Memory-mapped serial transmit peripheral that sits on the CPU data bus as a bus responder. It decodes a 4-byte register window, accepts byte writes into a small TX FIFO, and returns status and divisor contents combinationally on reads. It serializes queued bytes as 8N1 frames on `txd`, giving the CPU a console/debug output path with no wait states.

---
 rtl/uart_tx_port.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port: bus-mapped 8N1 serial transmitter with a small TX FIFO.
// Four-byte window: DATA (push), STATUS, DIV_L, DIV_H; reads are combinational.
module uart_tx_port #(
  parameter logic [15:0] BASE      = 16'hFF00,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic        read,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        txd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q;
  logic [15:0]   div_q, bit_cnt_q, reload;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic          txd_q;
  logic          empty, full, busy, pop, push_req, push_ok;
  logic          wr_status, wr_div_l, wr_div_h;
  logic          unused_read;

  assign unused_read = read;
  assign hit       = (address[15:2] == BASE[15:2]);
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign busy      = (state_q != IDLE);
  assign pop       = (state_q == IDLE) && !empty;
  assign push_req  = write && hit && (address[1:0] == 2'd0);
  assign wr_status = write && hit && (address[1:0] == 2'd1);
  assign wr_div_l  = write && hit && (address[1:0] == 2'd2);
  assign wr_div_h  = write && hit && (address[1:0] == 2'd3);
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign push_ok   = push_req && (!full || pop);
  assign reload    = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign txd       = txd_q;

  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (address[1:0])
        2'd1:    rdata = {4'b0000, ovr_q, busy, full, empty};
        2'd2:    rdata = div_q[7:0];
        2'd3:    rdata = div_q[15:8];
        default: rdata = 8'h00;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      div_q    <= DIV_RESET;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_req && full && !pop) begin
        ovr_q <= 1'b1;
      end else if (wr_status && wdata[3]) begin
        ovr_q <= 1'b0;
      end
      if (wr_div_l) div_q[7:0]  <= wdata;
      if (wr_div_h) div_q[15:8] <= wdata;
    end
  end

  // Each bit period reloads from the live divisor, so a divisor write
  // takes effect at the next bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            bit_cnt_q <= reload;
            txd_q     <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_cnt_q != 16'd0) begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end else begin
            bit_cnt_q <= reload;
            bit_idx_q <= 3'd0;
            txd_q     <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_cnt_q != 16'd0) begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end else begin
            bit_cnt_q <= reload;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bit_cnt_q != 16'd0) begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
